// File: rtl/seq_det_pkg.sv
// Shared types for the 011 sequence detector and its match event monitor.
// Holds FSM state encodings and the saturating-count helper.
package seq_det_pkg;

  typedef enum logic [1:0] {IDLE, RUN, ALARM} mon_state_t;

  typedef enum logic [1:0] {DET_S0, DET_S1, DET_S01} det_state_t;

  // Adds inc to value without passing max_val; callers cast back to their counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic inc,
                                          input logic [31:0] max_val);
    if (inc && (value < max_val)) return value + 32'd1;
    return value;
  endfunction

endpackage

// File: rtl/window_timer.sv
// Counts active cycles within a WIN_LEN window; last flags the closing active cycle.
// Cleared whenever the monitor is disabled so a resumed window starts fresh.
module window_timer #(
  parameter int WIN_LEN = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic clr,
  output logic last
);

  localparam int TMR_W = $clog2(WIN_LEN);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WIN_LEN - 1);

  logic [TMR_W-1:0] tmr;

  assign last = active && (tmr == TMR_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tmr <= '0;
    end else if (active) begin
      tmr <= last ? '0 : tmr + 1'b1;
    end
  end

endmodule

// File: rtl/match_event_monitor.sv
// Counts detector match pulses (lifetime and per window) and raises a sticky alarm
// when one window's count reaches THRESH; alarm holds until cleared.
module match_event_monitor
  import seq_det_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int WIN_LEN = 256,
  parameter int THRESH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             match,
  input  logic             clr_alarm,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] win_cnt,
  output logic             win_valid,
  output logic             alarm
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  mon_state_t       state;
  logic [CNT_W-1:0] run_cnt;
  logic             active;
  logic             last;
  logic             hit;

  assign active = (state != IDLE) && en;
  // Threshold is a crossing: only a match that lifts run_cnt onto THRESH counts.
  assign hit    = active && match && (run_cnt == CNT_W'(THRESH - 1));

  window_timer #(.WIN_LEN(WIN_LEN)) u_window_timer (
    .clk    (clk),
    .rst    (rst),
    .active (active),
    .clr    (!en),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      alarm <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) state <= RUN;
        end
        RUN: begin
          if (!en) begin
            state <= IDLE;
          end else if (hit) begin
            state <= ALARM;
            alarm <= 1'b1;
          end
        end
        ALARM: begin
          // A fresh hit outranks a simultaneous clear.
          if (!hit && clr_alarm) begin
            state <= en ? RUN : IDLE;
            alarm <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          alarm <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      total_cnt <= '0;
      win_cnt   <= '0;
      win_valid <= 1'b0;
      run_cnt   <= '0;
    end else begin
      win_valid <= last;
      if (active) begin
        total_cnt <= CNT_W'(sat_inc(32'(total_cnt), match, CNT_MAX));
      end
      if (!active) begin
        run_cnt <= '0;
      end else if (last) begin
        win_cnt <= CNT_W'(sat_inc(32'(run_cnt), match, CNT_MAX));
        run_cnt <= '0;
      end else begin
        run_cnt <= CNT_W'(sat_inc(32'(run_cnt), match, CNT_MAX));
      end
    end
  end

endmodule

// File: tb/tb_match_event_monitor.sv
// Directed bench for match_event_monitor with a cycle-level reference model
// checked every cycle, plus hand-computed expectations at key points.
module tb_match_event_monitor;

  localparam int CNT_W   = 4;
  localparam int WIN_LEN = 8;
  localparam int THRESH  = 3;
  localparam int MAXV    = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             en;
  logic             match;
  logic             clr_alarm;
  logic [CNT_W-1:0] total_cnt;
  logic [CNT_W-1:0] win_cnt;
  logic             win_valid;
  logic             alarm;

  int n_cmp = 0;
  int n_bad = 0;

  match_event_monitor #(.CNT_W(CNT_W), .WIN_LEN(WIN_LEN), .THRESH(THRESH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .match     (match),
    .clr_alarm (clr_alarm),
    .total_cnt (total_cnt),
    .win_cnt   (win_cnt),
    .win_valid (win_valid),
    .alarm     (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: monitor on/off, alarm flag, window position and counts as plain ints.
  int m_total, m_win, m_run, m_pos, m_sum;
  bit m_valid, m_alarm, m_on, m_seeded, m_act, m_hit;

  always @(posedge clk) begin
    if (rst) begin
      m_total = 0; m_win = 0; m_run = 0; m_pos = 0;
      m_valid = 0; m_alarm = 0; m_on = 0; m_seeded = 1;
    end else if (m_seeded) begin
      m_act = m_on && en;
      m_hit = 0;
      m_valid = 0;
      if (m_act) begin
        m_hit = match && (m_run + 1 == THRESH);
        m_sum = m_run + int'(match);
        if (m_sum > MAXV) m_sum = MAXV;
        if (match && m_total < MAXV) m_total++;
        if (m_pos == WIN_LEN - 1) begin
          m_win = m_sum; m_run = 0; m_pos = 0; m_valid = 1;
        end else begin
          m_run = m_sum; m_pos++;
        end
      end else if (!en) begin
        m_run = 0; m_pos = 0;
      end
      if (!m_on) m_on = en;
      else if (m_alarm) begin
        if (!m_hit && clr_alarm) begin m_alarm = 0; m_on = en; end
      end
      else if (!en) m_on = 0;
      else if (m_hit) m_alarm = 1;
    end
  end

  always @(posedge clk) begin
    #2;
    if (m_seeded) begin
      chk("model_total", 32'(total_cnt), 32'(m_total));
      chk("model_win",   32'(win_cnt),   32'(m_win));
      chk("model_valid", 32'(win_valid), 32'(m_valid));
      chk("model_alarm", 32'(alarm),     32'(m_alarm));
    end
  end

  task automatic cyc(input logic e, input logic m, input logic c);
    en = e; match = m; clr_alarm = c;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic valid_seen;

  initial begin
    rst = 1'b1; en = 1'b0; match = 1'b0; clr_alarm = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: disabled, match toggling
    valid_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'(i % 2), 1'b0);
      valid_seen = valid_seen | win_valid;
    end
    chk("t1_total", 32'(total_cnt), 0);
    chk("t1_win",   32'(win_cnt),   0);
    chk("t1_alarm", 32'(alarm),     0);
    chk("t1_no_valid", 32'(valid_seen), 0);

    // 2: matches at window positions 1 and 5
    cyc(1'b1, 1'b1, 1'b0);
    chk("t2_enter_ignored", 32'(total_cnt), 0);
    for (int i = 0; i < WIN_LEN; i++) begin
      cyc(1'b1, (i == 1 || i == 5), 1'b0);
      if (i == 5) chk("t2_total", 32'(total_cnt), 2);
      if (i == 6) chk("t2_valid_early", 32'(win_valid), 0);
    end
    chk("t2_valid", 32'(win_valid), 1);
    chk("t2_win",   32'(win_cnt),   2);
    chk("t2_alarm", 32'(alarm),     0);

    // 3: matches at 2, 4 and boundary 7 -> alarm
    for (int i = 0; i < WIN_LEN; i++) begin
      cyc(1'b1, (i == 2 || i == 4 || i == 7), 1'b0);
      if (i == 6) chk("t3_alarm_early", 32'(alarm), 0);
    end
    chk("t3_valid", 32'(win_valid), 1);
    chk("t3_win",   32'(win_cnt),   3);
    chk("t3_alarm", 32'(alarm),     1);
    chk("t3_total", 32'(total_cnt), 5);

    // 4: clear racing a hit, then a lone clear
    for (int i = 0; i < WIN_LEN; i++) begin
      cyc(1'b1, (i < 3), (i == 2 || i == 4));
      if (i == 2) chk("t4_race_alarm", 32'(alarm), 1);
      if (i == 4) chk("t4_clear_alarm", 32'(alarm), 0);
    end
    chk("t4_win",   32'(win_cnt),   3);
    chk("t4_total", 32'(total_cnt), 8);
    chk("t4_alarm", 32'(alarm),     0);

    // 5: 20 back-to-back matches
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      if (i == 1) chk("t5_alarm_pre", 32'(alarm), 0);
      if (i == 2) chk("t5_alarm_hit", 32'(alarm), 1);
      if (i == 7 || i == 15) chk("t5_win", 32'(win_cnt), 8);
      if (i == 7 || i == 15) chk("t5_valid", 32'(win_valid), 1);
    end
    chk("t5_total_sat", 32'(total_cnt), 15);
    chk("t5_alarm", 32'(alarm), 1);
    for (int i = 4; i < WIN_LEN; i++) cyc(1'b1, 1'b0, (i == 4));
    chk("t5_tail_win",   32'(win_cnt), 4);
    chk("t5_tail_alarm", 32'(alarm),   0);

    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    chk("rst_total", 32'(total_cnt), 0);

    // 6: disable mid-window and resume
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, (i == 1 || i == 3), 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      chk("t6_total_hold", 32'(total_cnt), 2);
      chk("t6_no_valid", 32'(win_valid), 0);
    end
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < WIN_LEN; i++) begin
      cyc(1'b1, (i == 0), 1'b0);
      if (i == 6) chk("t6_valid_early", 32'(win_valid), 0);
    end
    chk("t6_valid", 32'(win_valid), 1);
    chk("t6_win",   32'(win_cnt),   1);
    chk("t6_total", 32'(total_cnt), 3);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
    chk("t6_alarm_pre_rst", 32'(alarm), 1);
    chk("t6_total_pre_rst", 32'(total_cnt), 6);
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    chk("t6_rst_total", 32'(total_cnt), 0);
    chk("t6_rst_win",   32'(win_cnt),   0);
    chk("t6_rst_alarm", 32'(alarm),     0);
    chk("t6_rst_valid", 32'(win_valid), 0);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < WIN_LEN; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("t6_post_rst_valid", 32'(win_valid), 1);
    chk("t6_post_rst_win",   32'(win_cnt),   0);
    cyc(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
